// File: rtl/toy_pack.sv
// Shared definitions for the speculative rename map table and its checkpoint bank.
package toy_pack;

  localparam int DECODE_NUM       = 4;
  localparam int ARCH_NUM         = 32;
  localparam int PHY_REG_ID_WIDTH = 7;
  localparam int CKPT_NUM         = 8;
  localparam int CKPT_ID_W        = $clog2(CKPT_NUM);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } rat_state_e;

  typedef logic [CKPT_ID_W-1:0] ckpt_id_t;

endpackage

// File: rtl/toy_rename_ckpt_bank.sv
// Circular bank of map snapshots with head/tail/count bookkeeping and a
// registered (1-cycle latency) read port used by the recovery sequence.
module toy_rename_ckpt_bank
  import toy_pack::*;
#(
  parameter int ARCH_NUM  = toy_pack::ARCH_NUM,
  parameter int PHY_ID_W  = toy_pack::PHY_REG_ID_WIDTH,
  parameter int CKPT_NUM  = toy_pack::CKPT_NUM,
  parameter int CKPT_ID_W = $clog2(CKPT_NUM)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               i_flush,
  input  logic                               i_alloc,
  input  logic [ARCH_NUM-1:0][PHY_ID_W-1:0]  i_snap,
  input  logic                               i_free,
  input  logic                               i_recover,
  input  logic [CKPT_ID_W-1:0]               i_recover_id,
  input  logic [CKPT_ID_W-1:0]               i_rd_id,
  output logic [ARCH_NUM-1:0][PHY_ID_W-1:0]  o_rd_data,
  output logic [CKPT_ID_W-1:0]               o_tail,
  output logic [CKPT_ID_W:0]                 o_count
);

  logic [ARCH_NUM-1:0][PHY_ID_W-1:0] r_bank [CKPT_NUM];
  logic [ARCH_NUM-1:0][PHY_ID_W-1:0] r_rd_data;
  logic [CKPT_ID_W-1:0]              r_head;
  logic [CKPT_ID_W-1:0]              r_tail;
  logic [CKPT_ID_W:0]                r_count;
  logic                              w_free_ok;
  logic [CKPT_ID_W-1:0]              w_dist;

  // A free is dropped when the bank is empty, or when the recovery in the same
  // cycle targets the oldest entry (that entry is being discarded anyway).
  assign w_free_ok = i_free && (r_count != '0) && !(i_recover && (i_recover_id == r_head));
  assign w_dist    = i_recover_id - r_head;

  // Snapshot storage and registered read port (data only, no reset needed).
  always_ff @(posedge clk) begin
    if (i_alloc) r_bank[r_tail] <= i_snap;
    r_rd_data <= r_bank[i_rd_id];
  end

  // Head/tail/count: flush empties, recovery truncates at the restored entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_recover) begin
      r_tail  <= i_recover_id;
      r_head  <= r_head + CKPT_ID_W'(w_free_ok);
      r_count <= {1'b0, w_dist} - (CKPT_ID_W+1)'(w_free_ok);
    end else begin
      r_tail  <= r_tail + CKPT_ID_W'(i_alloc);
      r_head  <= r_head + CKPT_ID_W'(w_free_ok);
      r_count <= r_count + (CKPT_ID_W+1)'(i_alloc) - (CKPT_ID_W+1)'(w_free_ok);
    end
  end

  assign o_rd_data = r_rd_data;
  assign o_tail    = r_tail;
  assign o_count   = r_count;

endmodule

// File: rtl/toy_rename_rat_ckpt.sv
// Speculative rename map table with branch checkpoints for one register class.
// Optional performance counters are enabled with macro TOY_RAT_CKPT_PERF_EN.
module toy_rename_rat_ckpt
  import toy_pack::*;
#(
  parameter int DECODE_NUM = toy_pack::DECODE_NUM,
  parameter int ARCH_NUM   = toy_pack::ARCH_NUM,
  parameter int PHY_ID_W   = toy_pack::PHY_REG_ID_WIDTH,
  parameter int CKPT_NUM   = toy_pack::CKPT_NUM,
  parameter int CKPT_ID_W  = $clog2(CKPT_NUM),
  parameter int RESET_BASE = 0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [DECODE_NUM-1:0]               wr_en,
  input  logic [DECODE_NUM-1:0][4:0]          wr_arch,
  input  logic [DECODE_NUM-1:0][PHY_ID_W-1:0] wr_phy,
  input  logic                                ckpt_req,
  input  logic [$clog2(DECODE_NUM)-1:0]       ckpt_slot,
  output logic                                ckpt_ready,
  output logic [CKPT_ID_W-1:0]                ckpt_id,
  input  logic                                ckpt_free_en,
  input  logic                                recover_en,
  input  logic [CKPT_ID_W-1:0]                recover_id,
  input  logic                                flush_en,
  input  logic [ARCH_NUM-1:0][PHY_ID_W-1:0]   commit_phy,
  output logic [ARCH_NUM-1:0][PHY_ID_W-1:0]   map_phy,
  output logic                                rat_busy
`ifdef TOY_RAT_CKPT_PERF_EN
  ,
  output logic [31:0]                         perf_full_stall_cnt,
  output logic [31:0]                         perf_recover_cnt
`endif
);

  rat_state_e                        r_state;
  rat_state_e                        w_state_nxt;
  logic [ARCH_NUM-1:0][PHY_ID_W-1:0] r_map;
  logic [ARCH_NUM-1:0][PHY_ID_W-1:0] w_map_wr;
  logic [ARCH_NUM-1:0][PHY_ID_W-1:0] w_map_ck;
  logic [ARCH_NUM-1:0][PHY_ID_W-1:0] w_rd_data;
  logic [CKPT_ID_W-1:0]              r_rec_id;
  logic [CKPT_ID_W-1:0]              w_tail;
  logic [CKPT_ID_W:0]                w_count;
  logic                              w_idle;
  logic                              w_full;
  logic                              w_ops_ok;
  logic                              w_rec_acc;
  logic                              w_alloc;

  assign w_idle     = (r_state == IDLE);
  assign w_full     = (w_count == (CKPT_ID_W+1)'(CKPT_NUM));
  assign ckpt_ready = !w_full && w_idle;
  assign w_ops_ok   = w_idle && !recover_en && !flush_en;
  assign w_rec_acc  = w_idle && recover_en && !flush_en;
  assign w_alloc    = ckpt_req && ckpt_ready && !recover_en && !flush_en;
  assign ckpt_id    = w_tail;
  assign map_phy    = r_map;

  // Apply the rename group in slot order (younger slot wins); the snapshot
  // view stops after the branch slot.
  always_comb begin
    w_map_wr = r_map;
    w_map_ck = r_map;
    for (int i = 0; i < DECODE_NUM; i++) begin
      if (wr_en[i]) begin
        w_map_wr[wr_arch[i]] = wr_phy[i];
        if (i <= int'(ckpt_slot)) w_map_ck[wr_arch[i]] = wr_phy[i];
      end
    end
  end

  // Recovery FSM next state and busy indication; flush always returns to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    rat_busy    = 1'b0;
    case (r_state)
      IDLE: if (recover_en) w_state_nxt = RD;
      RD: begin
        w_state_nxt = WR;
        rat_busy    = 1'b1;
      end
      WR: begin
        w_state_nxt = IDLE;
        rat_busy    = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (flush_en) w_state_nxt = IDLE;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Latch the checkpoint to restore so the bank read address is stable in RD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_rec_id <= '0;
    else if (w_rec_acc) r_rec_id <= recover_id;
  end

  // Speculative map: flush beats restore, restore beats the rename group.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < ARCH_NUM; j++) r_map[j] <= PHY_ID_W'(j + RESET_BASE);
    end else if (flush_en) begin
      r_map <= commit_phy;
    end else if (r_state == WR) begin
      r_map <= w_rd_data;
    end else if (w_ops_ok) begin
      r_map <= w_map_wr;
    end
  end

  toy_rename_ckpt_bank #(
    .ARCH_NUM  (ARCH_NUM),
    .PHY_ID_W  (PHY_ID_W),
    .CKPT_NUM  (CKPT_NUM),
    .CKPT_ID_W (CKPT_ID_W)
  ) u_bank (
    .clk          (clk),
    .rst          (rst),
    .i_flush      (flush_en),
    .i_alloc      (w_alloc),
    .i_snap       (w_map_ck),
    .i_free       (ckpt_free_en),
    .i_recover    (w_rec_acc),
    .i_recover_id (recover_id),
    .i_rd_id      (r_rec_id),
    .o_rd_data    (w_rd_data),
    .o_tail       (w_tail),
    .o_count      (w_count)
  );

`ifdef TOY_RAT_CKPT_PERF_EN
  // Saturating event counters: checkpoint requests stalled by a full bank,
  // and recoveries actually started.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_full_stall_cnt <= '0;
      perf_recover_cnt    <= '0;
    end else begin
      if (ckpt_req && w_full && (perf_full_stall_cnt != '1))
        perf_full_stall_cnt <= perf_full_stall_cnt + 32'd1;
      if (w_rec_acc && (perf_recover_cnt != '1))
        perf_recover_cnt <= perf_recover_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_toy_rename_rat_ckpt.sv
// Self-checking bench for toy_rename_rat_ckpt: directed scenarios with literal
// expectations, then randomized traffic checked against a behavioural model.
module tb_toy_rename_rat_ckpt;

  localparam int D  = 4;
  localparam int A  = 32;
  localparam int P  = 7;
  localparam int N  = 8;
  localparam int IW = 3;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [D-1:0]         wr_en;
  logic [D-1:0][4:0]    wr_arch;
  logic [D-1:0][P-1:0]  wr_phy;
  logic                 ckpt_req;
  logic [1:0]           ckpt_slot;
  logic                 ckpt_ready, ckpt_ready2;
  logic [IW-1:0]        ckpt_id, ckpt_id2;
  logic                 ckpt_free_en;
  logic                 recover_en;
  logic [IW-1:0]        recover_id;
  logic                 flush_en;
  logic [A-1:0][P-1:0]  commit_phy;
  logic [A-1:0][P-1:0]  map_phy, map_phy2;
  logic                 rat_busy, rat_busy2;
`ifdef TOY_RAT_CKPT_PERF_EN
  logic [31:0] pf1, pr1, pf2, pr2;
`endif

  always #5 clk = ~clk;

  toy_rename_rat_ckpt dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_arch(wr_arch), .wr_phy(wr_phy),
    .ckpt_req(ckpt_req), .ckpt_slot(ckpt_slot), .ckpt_ready(ckpt_ready), .ckpt_id(ckpt_id),
    .ckpt_free_en(ckpt_free_en), .recover_en(recover_en), .recover_id(recover_id),
    .flush_en(flush_en), .commit_phy(commit_phy), .map_phy(map_phy), .rat_busy(rat_busy)
`ifdef TOY_RAT_CKPT_PERF_EN
    , .perf_full_stall_cnt(pf1), .perf_recover_cnt(pr1)
`endif
  );

  toy_rename_rat_ckpt #(.RESET_BASE(32)) dut_base32 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_arch(wr_arch), .wr_phy(wr_phy),
    .ckpt_req(ckpt_req), .ckpt_slot(ckpt_slot), .ckpt_ready(ckpt_ready2), .ckpt_id(ckpt_id2),
    .ckpt_free_en(ckpt_free_en), .recover_en(recover_en), .recover_id(recover_id),
    .flush_en(flush_en), .commit_phy(commit_phy), .map_phy(map_phy2), .rat_busy(rat_busy2)
`ifdef TOY_RAT_CKPT_PERF_EN
    , .perf_full_stall_cnt(pf2), .perf_recover_cnt(pr2)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Behavioural model: the map as an array, checkpoints as whole map copies,
  // a busy countdown standing in for the restore sequence.
  logic [P-1:0] m_map  [A];
  logic [P-1:0] m_bank [N][A];
  int m_head, m_tail, m_count, m_busy, m_rec;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < A; j++) m_map[j] = P'(j);
    m_head = 0; m_tail = 0; m_count = 0; m_busy = 0; m_rec = 0;
  endtask

  task automatic model_step();
    int fo;
    if (flush_en) begin
      for (int j = 0; j < A; j++) m_map[j] = commit_phy[j];
      m_head = 0; m_tail = 0; m_count = 0; m_busy = 0;
      return;
    end
    fo = (ckpt_free_en && m_count > 0) ? 1 : 0;
    if (m_busy > 0) begin
      if (m_busy == 1) for (int j = 0; j < A; j++) m_map[j] = m_bank[m_rec][j];
      m_busy--;
      m_head  = (m_head + fo) % N;
      m_count = m_count - fo;
      return;
    end
    if (recover_en) begin
      if (int'(recover_id) == m_head) fo = 0;
      m_rec   = int'(recover_id);
      m_count = ((int'(recover_id) - m_head + N) % N) - fo;
      m_head  = (m_head + fo) % N;
      m_tail  = int'(recover_id);
      m_busy  = 2;
      return;
    end
    if (ckpt_req && m_count != N) begin
      for (int j = 0; j < A; j++) m_bank[m_tail][j] = m_map[j];
      for (int i = 0; i <= int'(ckpt_slot); i++)
        if (wr_en[i]) m_bank[m_tail][wr_arch[i]] = wr_phy[i];
      m_tail  = (m_tail + 1) % N;
      m_count = m_count + 1;
    end
    for (int i = 0; i < D; i++)
      if (wr_en[i]) m_map[wr_arch[i]] = wr_phy[i];
    m_head  = (m_head + fo) % N;
    m_count = m_count - fo;
  endtask

  task automatic compare();
    int bad;
    bad = -1;
    for (int j = A - 1; j >= 0; j--) if (map_phy[j] !== m_map[j]) bad = j;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL map_phy[%0d]: got %0d expected %0d", bad, map_phy[bad], m_map[bad]);
    end
    chk("rat_busy", 32'(rat_busy), 32'(m_busy > 0));
    chk("ckpt_ready", 32'(ckpt_ready), 32'(m_count != N && m_busy == 0));
    chk("ckpt_id", 32'(ckpt_id), 32'(m_tail));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  task automatic idle_in();
    wr_en = '0; wr_arch = '0; wr_phy = '0;
    ckpt_req = 1'b0; ckpt_slot = '0; ckpt_free_en = 1'b0;
    recover_en = 1'b0; recover_id = '0; flush_en = 1'b0;
    for (int j = 0; j < A; j++) commit_phy[j] = P'(j);
  endtask

  task automatic group_r3();
    wr_en = 4'b0101;
    wr_arch[0] = 5'd3; wr_phy[0] = 7'd40;
    wr_arch[2] = 5'd3; wr_phy[2] = 7'd41;
  endtask

  initial begin
    rst = 1'b1;
    idle_in();
    model_reset();
    #22;
    rst = 1'b0;
    #1;
    // reset state
    chk("reset_map5", 32'(map_phy[5]), 32'd5);
    chk("reset_ready", 32'(ckpt_ready), 32'd1);
    chk("reset_busy", 32'(rat_busy), 32'd0);
    chk("reset_base32_map5", 32'(map_phy2[5]), 32'd37);
    compare();

    // same-arch conflict inside a group: highest slot wins
    group_r3();
    cyc();
    chk("conflict_map3", 32'(map_phy[3]), 32'd41);

    // mid-group snapshot at slot 1, then recover from it
    idle_in(); group_r3(); ckpt_req = 1'b1; ckpt_slot = 2'd1;
    chk("first_ckpt_id", 32'(ckpt_id), 32'd0);
    cyc();
    chk("post_ckpt_map3", 32'(map_phy[3]), 32'd41);
    idle_in(); recover_en = 1'b1; recover_id = 3'd0;
    cyc();
    chk("rec_busy_rd", 32'(rat_busy), 32'd1);
    idle_in();
    cyc();
    chk("rec_busy_wr", 32'(rat_busy), 32'd1);
    cyc();
    chk("rec_done_busy", 32'(rat_busy), 32'd0);
    chk("rec_map3", 32'(map_phy[3]), 32'd40);
    chk("rec_ckpt_id", 32'(ckpt_id), 32'd0);

    // fill the bank, overflow attempt, then free one and wrap
    ckpt_req = 1'b1;
    for (int k = 0; k < 8; k++) cyc();
    chk("full_ready", 32'(ckpt_ready), 32'd0);
    cyc();
    chk("full_ignored_id", 32'(ckpt_id), 32'd0);
    idle_in(); ckpt_free_en = 1'b1;
    cyc();
    chk("free_ready", 32'(ckpt_ready), 32'd1);
    chk("free_wrap_id", 32'(ckpt_id), 32'd0);

    // flush during the bank-read state
    idle_in(); recover_en = 1'b1; recover_id = 3'd1;
    cyc();
    idle_in(); flush_en = 1'b1; commit_phy[3] = 7'd12;
    cyc();
    chk("flush_map3", 32'(map_phy[3]), 32'd12);
    chk("flush_busy", 32'(rat_busy), 32'd0);
    chk("flush_id", 32'(ckpt_id), 32'd0);

    // recover id 2 with head 0, count 5 -> count 2
    idle_in(); ckpt_req = 1'b1;
    for (int k = 0; k < 5; k++) cyc();
    idle_in(); recover_en = 1'b1; recover_id = 3'd2;
    cyc();
    idle_in();
    cyc(); cyc();
    chk("rec2_id", 32'(ckpt_id), 32'd2);
    ckpt_req = 1'b1;
    for (int k = 0; k < 5; k++) cyc();
    chk("rec2_count7_ready", 32'(ckpt_ready), 32'd1);
    cyc();
    chk("rec2_count8_ready", 32'(ckpt_ready), 32'd0);

    // asynchronous reset in the middle of a recovery
    idle_in(); recover_en = 1'b1; recover_id = 3'd3;
    cyc();
    idle_in();
    rst = 1'b1;
    #1;
    model_reset();
    chk("arst_busy", 32'(rat_busy), 32'd0);
    chk("arst_map3", 32'(map_phy[3]), 32'd3);
    chk("arst_ready", 32'(ckpt_ready), 32'd1);
    chk("arst_id", 32'(ckpt_id), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      wr_en = D'($urandom);
      for (int i = 0; i < D; i++) begin
        wr_arch[i] = 5'($urandom);
        wr_phy[i]  = P'($urandom);
      end
      ckpt_req     = ($urandom % 10) < 4;
      ckpt_slot    = 2'($urandom);
      ckpt_free_en = ($urandom % 4) == 0;
      recover_en   = 1'b0;
      recover_id   = IW'($urandom);
      if (m_count > 0 && ($urandom % 16) == 0) begin
        recover_en = 1'b1;
        recover_id = IW'((m_head + int'($urandom % 32'(m_count))) % N);
      end else if (($urandom % 40) == 0) begin
        recover_en = 1'b1;
      end
      if (recover_en && m_busy == 0 && m_count == 0) recover_en = 1'b0;
      flush_en = ($urandom % 60) == 0;
      for (int j = 0; j < A; j++) commit_phy[j] = P'($urandom);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
